// File: rtl/ccip_throttle_pkg.sv
// Shared types and constants for the CCI-P Tx throttle: a compact CCI-P
// interface subset plus the throttle's default sizing and counter width.
package ccip_throttle_pkg;

  localparam int CCIP_CLDATA_WIDTH              = 512;
  localparam int CCIP_MMIODATA_WIDTH            = 64;
  localparam int CCIP_CLADDR_WIDTH              = 42;
  localparam int CCIP_MDATA_WIDTH               = 16;
  localparam int THR_DEFAULT_FIFO_DEPTH         = 8;
  localparam int THR_DEFAULT_MAX_OUTSTANDING_RD = 256;
  localparam int RD_CNT_W                       = 10;

  // Encoded line count: 0 -> 1 line, 1 -> 2 lines, 3 -> 4 lines.
  typedef logic [1:0] t_ccip_clLen;
  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr            hdr;
    logic                           mmioRdValid;
    logic [CCIP_MMIODATA_WIDTH-1:0] data;
  } t_ccip_c2_TxData;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr           hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic                         rspValid;
    logic                         mmioRdValid;
    logic                         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr           hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic                         valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx  c0;
    t_if_ccip_c1_Tx  c1;
    t_ccip_c2_TxData c2;
  } t_if_ccip_Tx;

  // Number of cache lines a read request occupies, widened to the counter.
  function automatic logic [RD_CNT_W-1:0] cl_lines(input t_ccip_clLen len);
    return RD_CNT_W'(len) + RD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ccip_sync_fifo.sv
// Single-clock skid FIFO with a registered ready (not full) flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module ccip_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             ready_q;
  logic             do_push;
  logic             do_pop;

  // ready_q is held low through reset so it rises the cycle after release.
  assign ready   = ready_q & ~srst;
  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt < FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ccip_tx_throttle.sv
// CCI-P Tx throttle: per-channel skid FIFOs in front of the async shim,
// honouring AlmFull and capping outstanding read cache lines.
module ccip_tx_throttle
  import ccip_throttle_pkg::*;
#(
  parameter int FIFO_DEPTH         = THR_DEFAULT_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING_RD = THR_DEFAULT_MAX_OUTSTANDING_RD
) (
  input  logic                         afu_clk,
  input  logic                         afu_softreset,
  input  logic                         usr_c0_valid,
  input  t_ccip_c0_ReqMemHdr           usr_c0_hdr,
  output logic                         usr_c0_ready,
  input  logic                         usr_c1_valid,
  input  t_ccip_c1_ReqMemHdr           usr_c1_hdr,
  input  logic [CCIP_CLDATA_WIDTH-1:0] usr_c1_data,
  output logic                         usr_c1_ready,
  input  t_ccip_c2_TxData              usr_c2,
  input  t_if_ccip_Rx                  afu_rx,
  output t_if_ccip_Tx                  afu_tx,
  output logic [RD_CNT_W-1:0]          rd_outstanding,
  output logic                         err_underflow
);
  localparam int C0_W = $bits(t_ccip_c0_ReqMemHdr);
  localparam int C1_W = $bits(t_ccip_c1_ReqMemHdr) + CCIP_CLDATA_WIDTH;
  localparam logic [RD_CNT_W:0] RD_CAP = MAX_OUTSTANDING_RD[RD_CNT_W:0];

  t_ccip_c0_ReqMemHdr           c0_head;
  t_ccip_c1_ReqMemHdr           c1_head_hdr;
  logic [CCIP_CLDATA_WIDTH-1:0] c1_head_data;
  logic [C1_W-1:0]              c1_head;
  logic                         c0_empty;
  logic                         c1_empty;
  logic                         c0_fits;
  logic                         c0_issue;
  logic                         c1_issue;
  logic [RD_CNT_W-1:0]          c0_lines;
  logic [RD_CNT_W-1:0]          rd_cnt_nxt;
  logic                         rsp_rdline;
  logic                         underflow;
  logic                         unused_rx;

  // User side: a request transfers on a cycle where valid & ready are both 1;
  // ready depends only on registered state, never on valid.
  ccip_sync_fifo #(.WIDTH(C0_W), .DEPTH(FIFO_DEPTH)) u_c0_fifo (
    .clk   (afu_clk),
    .srst  (afu_softreset),
    .push  (usr_c0_valid),
    .din   (usr_c0_hdr),
    .pop   (c0_issue),
    .dout  (c0_head),
    .empty (c0_empty),
    .ready (usr_c0_ready)
  );

  ccip_sync_fifo #(.WIDTH(C1_W), .DEPTH(FIFO_DEPTH)) u_c1_fifo (
    .clk   (afu_clk),
    .srst  (afu_softreset),
    .push  (usr_c1_valid),
    .din   ({usr_c1_hdr, usr_c1_data}),
    .pop   (c1_issue),
    .dout  (c1_head),
    .empty (c1_empty),
    .ready (usr_c1_ready)
  );

  assign {c1_head_hdr, c1_head_data} = c1_head;

  // Extra MSB keeps the cap comparison free of wraparound near 1023.
  assign c0_lines = cl_lines(c0_head.cl_len);
  assign c0_fits  = ({1'b0, rd_outstanding} + {1'b0, c0_lines}) <= RD_CAP;
  assign c0_issue = ~c0_empty & ~afu_rx.c0TxAlmFull & c0_fits;
  assign c1_issue = ~c1_empty & ~afu_rx.c1TxAlmFull;

  assign rsp_rdline = afu_rx.c0.rspValid & (afu_rx.c0.hdr.resp_type == eRSP_RDLINE);
  assign underflow  = rsp_rdline & (rd_outstanding == '0);
  assign unused_rx  = ^afu_rx;

  always_comb begin
    rd_cnt_nxt = rd_outstanding;
    if (c0_issue) rd_cnt_nxt = rd_cnt_nxt + c0_lines;
    if (rsp_rdline && !underflow) rd_cnt_nxt = rd_cnt_nxt - RD_CNT_W'(1);
  end

  always_ff @(posedge afu_clk) begin
    if (afu_softreset) begin
      afu_tx         <= '0;
      rd_outstanding <= '0;
      err_underflow  <= 1'b0;
    end else begin
      afu_tx.c0.valid <= c0_issue;
      afu_tx.c0.hdr   <= c0_issue ? c0_head : '0;
      afu_tx.c1.valid <= c1_issue;
      afu_tx.c1.hdr   <= c1_issue ? c1_head_hdr : '0;
      afu_tx.c1.data  <= c1_issue ? c1_head_data : '0;
      afu_tx.c2       <= usr_c2;
      rd_outstanding  <= rd_cnt_nxt;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_tx_throttle.sv
// Directed bench for ccip_tx_throttle: a default-sized instance plus a
// second instance with a 4-line read cap.
module tb_ccip_tx_throttle;
  import ccip_throttle_pkg::*;

  logic                         afu_clk = 1'b0;
  logic                         afu_softreset;
  logic                         usr_c0_valid;
  t_ccip_c0_ReqMemHdr           usr_c0_hdr;
  logic                         usr_c0_ready;
  logic                         usr_c1_valid;
  t_ccip_c1_ReqMemHdr           usr_c1_hdr;
  logic [CCIP_CLDATA_WIDTH-1:0] usr_c1_data;
  logic                         usr_c1_ready;
  t_ccip_c2_TxData              usr_c2;
  t_if_ccip_Rx                  afu_rx;
  t_if_ccip_Tx                  afu_tx;
  logic [RD_CNT_W-1:0]          rd_outstanding;
  logic                         err_underflow;

  logic                         cap_c0_valid;
  t_ccip_c0_ReqMemHdr           cap_c0_hdr;
  logic                         cap_c0_ready;
  logic                         cap_c1_ready;
  t_if_ccip_Rx                  cap_rx;
  t_if_ccip_Tx                  cap_tx;
  logic [RD_CNT_W-1:0]          cap_rd_outstanding;
  logic                         cap_err_underflow;

  int errors = 0;
  int checks = 0;
  logic [CCIP_CLADDR_WIDTH-1:0] exp_q[$];

  // Clock / reset
  always #5 afu_clk = ~afu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  ccip_tx_throttle dut (
    .afu_clk        (afu_clk),
    .afu_softreset  (afu_softreset),
    .usr_c0_valid   (usr_c0_valid),
    .usr_c0_hdr     (usr_c0_hdr),
    .usr_c0_ready   (usr_c0_ready),
    .usr_c1_valid   (usr_c1_valid),
    .usr_c1_hdr     (usr_c1_hdr),
    .usr_c1_data    (usr_c1_data),
    .usr_c1_ready   (usr_c1_ready),
    .usr_c2         (usr_c2),
    .afu_rx         (afu_rx),
    .afu_tx         (afu_tx),
    .rd_outstanding (rd_outstanding),
    .err_underflow  (err_underflow)
  );

  ccip_tx_throttle #(.FIFO_DEPTH(8), .MAX_OUTSTANDING_RD(4)) dut_cap (
    .afu_clk        (afu_clk),
    .afu_softreset  (afu_softreset),
    .usr_c0_valid   (cap_c0_valid),
    .usr_c0_hdr     (cap_c0_hdr),
    .usr_c0_ready   (cap_c0_ready),
    .usr_c1_valid   (1'b0),
    .usr_c1_hdr     ('0),
    .usr_c1_data    ('0),
    .usr_c1_ready   (cap_c1_ready),
    .usr_c2         ('0),
    .afu_rx         (cap_rx),
    .afu_tx         (cap_tx),
    .rd_outstanding (cap_rd_outstanding),
    .err_underflow  (cap_err_underflow)
  );

  // Driver tasks
  task automatic drive_c0(input logic [CCIP_CLADDR_WIDTH-1:0] addr, input logic [1:0] len);
    usr_c0_hdr          = '0;
    usr_c0_hdr.address  = addr;
    usr_c0_hdr.cl_len   = len;
    usr_c0_hdr.req_type = eREQ_RDLINE_I;
    usr_c0_valid        = 1'b1;
  endtask

  task automatic rd_rsp(input logic v);
    afu_rx.c0.rspValid      = v;
    afu_rx.c0.hdr.resp_type = eRSP_RDLINE;
  endtask

  task automatic cap_rsp(input logic v);
    cap_rx.c0.rspValid      = v;
    cap_rx.c0.hdr.resp_type = eRSP_RDLINE;
  endtask

  // Tests
  task automatic test_reset;
    repeat (3) @(negedge afu_clk);
    checks++; if (usr_c0_ready !== 1'b0) begin errors++; $display("FAIL rst_c0_ready: got %b exp 0", usr_c0_ready); end
    checks++; if (usr_c1_ready !== 1'b0) begin errors++; $display("FAIL rst_c1_ready: got %b exp 0", usr_c1_ready); end
    checks++; if (afu_tx !== '0) begin errors++; $display("FAIL rst_afu_tx: got nonzero exp 0"); end
    checks++; if (rd_outstanding !== '0) begin errors++; $display("FAIL rst_rd_out: got %0d exp 0", rd_outstanding); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err_underflow); end
    afu_softreset = 1'b0;
    #1;
    checks++; if (usr_c0_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready_early: got %b exp 0", usr_c0_ready); end
    @(negedge afu_clk);
    checks++; if (usr_c0_ready !== 1'b1) begin errors++; $display("FAIL rst_release_c0_ready: got %b exp 1", usr_c0_ready); end
    checks++; if (usr_c1_ready !== 1'b1) begin errors++; $display("FAIL rst_release_c1_ready: got %b exp 1", usr_c1_ready); end
    checks++; if (cap_c0_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cap_ready: got %b exp 1", cap_c0_ready); end
  endtask

  task automatic test_reads;
    for (int i = 0; i < 4; i++) begin
      drive_c0(CCIP_CLADDR_WIDTH'(16 + i), 2'd0);
      @(negedge afu_clk);
      usr_c0_valid = 1'b0;
      checks++; if (afu_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL reads_lat1_valid[%0d]: got %b exp 0", i, afu_tx.c0.valid); end
      @(negedge afu_clk);
      checks++; if (afu_tx.c0.valid !== 1'b1) begin errors++; $display("FAIL reads_lat2_valid[%0d]: got %b exp 1", i, afu_tx.c0.valid); end
      checks++; if (afu_tx.c0.hdr.address !== CCIP_CLADDR_WIDTH'(16 + i)) begin errors++; $display("FAIL reads_addr[%0d]: got %0d exp %0d", i, afu_tx.c0.hdr.address, 16 + i); end
      checks++; if (rd_outstanding !== RD_CNT_W'(i + 1)) begin errors++; $display("FAIL reads_rd_out[%0d]: got %0d exp %0d", i, rd_outstanding, i + 1); end
      @(negedge afu_clk);
      checks++; if (afu_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL reads_pulse_end[%0d]: got %b exp 0", i, afu_tx.c0.valid); end
      checks++; if (afu_tx.c0.hdr !== '0) begin errors++; $display("FAIL reads_hdr_zero[%0d]: got %h exp 0", i, afu_tx.c0.hdr); end
    end
    // A non-RDLINE response must not move the counter.
    afu_rx.c0.rspValid      = 1'b1;
    afu_rx.c0.hdr.resp_type = eRSP_UMSG;
    @(negedge afu_clk);
    afu_rx.c0.rspValid = 1'b0;
    checks++; if (rd_outstanding !== 10'd4) begin errors++; $display("FAIL reads_umsg_ignored: got %0d exp 4", rd_outstanding); end
    rd_rsp(1'b1);
    repeat (4) @(negedge afu_clk);
    rd_rsp(1'b0);
    checks++; if (rd_outstanding !== 10'd0) begin errors++; $display("FAIL reads_drained: got %0d exp 0", rd_outstanding); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reads_no_underflow: got %b exp 0", err_underflow); end
  endtask

  task automatic test_writes_c2;
    logic [CCIP_CLDATA_WIDTH-1:0] wdata;
    wdata                = {8{64'hDEAD_BEEF_0000_0001}};
    usr_c1_hdr           = '0;
    usr_c1_hdr.address   = 42'h123;
    usr_c1_hdr.sop       = 1'b1;
    usr_c1_data          = wdata;
    usr_c1_valid         = 1'b1;
    usr_c2               = '0;
    usr_c2.hdr.tid       = 9'h055;
    usr_c2.mmioRdValid   = 1'b1;
    usr_c2.data          = 64'h0000_0000_0000_CAFE;
    @(negedge afu_clk);
    usr_c1_valid = 1'b0;
    usr_c2       = '0;
    checks++; if (afu_tx.c2.mmioRdValid !== 1'b1 || afu_tx.c2.hdr.tid !== 9'h055 || afu_tx.c2.data !== 64'hCAFE) begin errors++; $display("FAIL c2_delay: got v=%b tid=%h d=%h exp v=1 tid=055 d=cafe", afu_tx.c2.mmioRdValid, afu_tx.c2.hdr.tid, afu_tx.c2.data); end
    checks++; if (afu_tx.c1.valid !== 1'b0) begin errors++; $display("FAIL wr_lat1_valid: got %b exp 0", afu_tx.c1.valid); end
    @(negedge afu_clk);
    checks++; if (afu_tx.c1.valid !== 1'b1) begin errors++; $display("FAIL wr_lat2_valid: got %b exp 1", afu_tx.c1.valid); end
    checks++; if (afu_tx.c1.hdr.address !== 42'h123) begin errors++; $display("FAIL wr_addr: got %h exp 123", afu_tx.c1.hdr.address); end
    checks++; if (afu_tx.c1.data !== wdata) begin errors++; $display("FAIL wr_data: got %h exp %h", afu_tx.c1.data, wdata); end
    checks++; if (afu_tx.c2.mmioRdValid !== 1'b0) begin errors++; $display("FAIL c2_clear: got %b exp 0", afu_tx.c2.mmioRdValid); end
    checks++; if (rd_outstanding !== 10'd0) begin errors++; $display("FAIL wr_not_counted: got %0d exp 0", rd_outstanding); end
    @(negedge afu_clk);
    checks++; if (afu_tx.c1.valid !== 1'b0 || afu_tx.c1.data !== '0) begin errors++; $display("FAIL wr_idle_zero: got v=%b exp v=0 data=0", afu_tx.c1.valid); end
  endtask

  task automatic test_almfull;
    int seen;
    logic [CCIP_CLADDR_WIDTH-1:0] exp_addr;
    seen = 0;
    afu_rx.c0TxAlmFull = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (usr_c0_ready !== 1'b1) begin errors++; $display("FAIL af_ready_before_push[%0d]: got %b exp 1", i, usr_c0_ready); end
      drive_c0(CCIP_CLADDR_WIDTH'(100 + i), 2'd0);
      exp_q.push_back(CCIP_CLADDR_WIDTH'(100 + i));
      @(negedge afu_clk);
      if (afu_tx.c0.valid === 1'b1) seen++;
    end
    usr_c0_valid = 1'b0;
    checks++; if (usr_c0_ready !== 1'b0) begin errors++; $display("FAIL af_ready_full: got %b exp 0", usr_c0_ready); end
    repeat (3) begin
      @(negedge afu_clk);
      if (afu_tx.c0.valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL af_no_issue: got %0d issues exp 0", seen); end
    afu_rx.c0TxAlmFull = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge afu_clk);
      exp_addr = exp_q.pop_front();
      checks++; if (afu_tx.c0.valid !== 1'b1 || afu_tx.c0.hdr.address !== exp_addr) begin errors++; $display("FAIL af_release_issue[%0d]: got v=%b a=%0d exp v=1 a=%0d", i, afu_tx.c0.valid, afu_tx.c0.hdr.address, exp_addr); end
      if (i == 0) begin
        checks++; if (usr_c0_ready !== 1'b1) begin errors++; $display("FAIL af_ready_after_pop: got %b exp 1", usr_c0_ready); end
      end
    end
    @(negedge afu_clk);
    checks++; if (afu_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL af_drained: got %b exp 0", afu_tx.c0.valid); end
    checks++; if (rd_outstanding !== 10'd8) begin errors++; $display("FAIL af_rd_out: got %0d exp 8", rd_outstanding); end
  endtask

  task automatic test_net_update;
    rd_rsp(1'b1);
    repeat (3) @(negedge afu_clk);
    rd_rsp(1'b0);
    checks++; if (rd_outstanding !== 10'd5) begin errors++; $display("FAIL net_pre: got %0d exp 5", rd_outstanding); end
    drive_c0(42'd200, 2'd3);
    @(negedge afu_clk);
    usr_c0_valid = 1'b0;
    rd_rsp(1'b1);
    checks++; if (rd_outstanding !== 10'd5) begin errors++; $display("FAIL net_hold: got %0d exp 5", rd_outstanding); end
    @(negedge afu_clk);
    rd_rsp(1'b0);
    checks++; if (afu_tx.c0.valid !== 1'b1 || afu_tx.c0.hdr.cl_len !== 2'd3) begin errors++; $display("FAIL net_issue: got v=%b len=%0d exp v=1 len=3", afu_tx.c0.valid, afu_tx.c0.hdr.cl_len); end
    checks++; if (rd_outstanding !== 10'd8) begin errors++; $display("FAIL net_value: got %0d exp 8", rd_outstanding); end
  endtask

  task automatic test_underflow;
    rd_rsp(1'b1);
    repeat (8) @(negedge afu_clk);
    rd_rsp(1'b0);
    checks++; if (rd_outstanding !== 10'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL uf_pre: got cnt=%0d err=%b exp cnt=0 err=0", rd_outstanding, err_underflow); end
    rd_rsp(1'b1);
    @(negedge afu_clk);
    rd_rsp(1'b0);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b exp 1", err_underflow); end
    checks++; if (rd_outstanding !== 10'd0) begin errors++; $display("FAIL uf_cnt: got %0d exp 0", rd_outstanding); end
    repeat (3) @(negedge afu_clk);
    checks++; if (err_underflow !== 1'b1 || rd_outstanding !== 10'd0) begin errors++; $display("FAIL uf_sticky: got err=%b cnt=%0d exp err=1 cnt=0", err_underflow, rd_outstanding); end
  endtask

  task automatic test_cap;
    int seen;
    seen         = 0;
    cap_c0_hdr   = '0;
    cap_c0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cap_c0_hdr.address = CCIP_CLADDR_WIDTH'(300 + i);
      @(negedge afu_clk);
    end
    cap_c0_valid = 1'b0;
    repeat (3) @(negedge afu_clk);
    checks++; if (cap_rd_outstanding !== 10'd4) begin errors++; $display("FAIL cap_fill: got %0d exp 4", cap_rd_outstanding); end
    cap_c0_hdr.address = 42'd400;
    cap_c0_hdr.cl_len  = 2'd1;
    cap_c0_valid       = 1'b1;
    @(negedge afu_clk);
    cap_c0_valid = 1'b0;
    repeat (4) begin
      @(negedge afu_clk);
      if (cap_tx.c0.valid === 1'b1) seen++;
    end
    checks++; if (seen != 0 || cap_rd_outstanding !== 10'd4) begin errors++; $display("FAIL cap_blocked: got issues=%0d cnt=%0d exp issues=0 cnt=4", seen, cap_rd_outstanding); end
    cap_rsp(1'b1);
    @(negedge afu_clk);
    cap_rsp(1'b0);
    checks++; if (cap_rd_outstanding !== 10'd3 || cap_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL cap_rsp1: got cnt=%0d v=%b exp cnt=3 v=0", cap_rd_outstanding, cap_tx.c0.valid); end
    @(negedge afu_clk);
    checks++; if (cap_rd_outstanding !== 10'd3 || cap_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL cap_still_blocked: got cnt=%0d v=%b exp cnt=3 v=0", cap_rd_outstanding, cap_tx.c0.valid); end
    cap_rsp(1'b1);
    @(negedge afu_clk);
    cap_rsp(1'b0);
    checks++; if (cap_rd_outstanding !== 10'd2 || cap_tx.c0.valid !== 1'b0) begin errors++; $display("FAIL cap_rsp2: got cnt=%0d v=%b exp cnt=2 v=0", cap_rd_outstanding, cap_tx.c0.valid); end
    @(negedge afu_clk);
    checks++; if (cap_tx.c0.valid !== 1'b1 || cap_tx.c0.hdr.address !== 42'd400) begin errors++; $display("FAIL cap_issue: got v=%b a=%0d exp v=1 a=400", cap_tx.c0.valid, cap_tx.c0.hdr.address); end
    checks++; if (cap_rd_outstanding !== 10'd4) begin errors++; $display("FAIL cap_after_issue: got %0d exp 4", cap_rd_outstanding); end
  endtask

  task automatic test_reset_midop;
    int seen;
    seen               = 0;
    afu_rx.c1TxAlmFull = 1'b1;
    usr_c1_hdr         = '0;
    usr_c1_valid       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      usr_c1_hdr.address = CCIP_CLADDR_WIDTH'(500 + i);
      usr_c1_data        = CCIP_CLDATA_WIDTH'(i + 1);
      @(negedge afu_clk);
    end
    usr_c1_valid = 1'b0;
    checks++; if (usr_c1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_q5: got %b exp 1", usr_c1_ready); end
    afu_softreset = 1'b1;
    #1;
    checks++; if (usr_c1_ready !== 1'b0 || usr_c0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got c0=%b c1=%b exp 0 0", usr_c0_ready, usr_c1_ready); end
    @(negedge afu_clk);
    afu_softreset      = 1'b0;
    afu_rx.c1TxAlmFull = 1'b0;
    checks++; if (usr_c1_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_at_release: got %b exp 0", usr_c1_ready); end
    checks++; if (err_underflow !== 1'b0 || rd_outstanding !== 10'd0) begin errors++; $display("FAIL mid_state_cleared: got err=%b cnt=%0d exp 0 0", err_underflow, rd_outstanding); end
    checks++; if (afu_tx.c1.valid !== 1'b0) begin errors++; $display("FAIL mid_c1_valid_reset: got %b exp 0", afu_tx.c1.valid); end
    @(negedge afu_clk);
    if (afu_tx.c1.valid === 1'b1) seen++;
    checks++; if (usr_c1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_next_cycle: got %b exp 1", usr_c1_ready); end
    repeat (6) begin
      @(negedge afu_clk);
      if (afu_tx.c1.valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_discarded: got %0d c1 issues exp 0", seen); end
  endtask

  initial begin
    afu_softreset = 1'b1;
    usr_c0_valid  = 1'b0;
    usr_c0_hdr    = '0;
    usr_c1_valid  = 1'b0;
    usr_c1_hdr    = '0;
    usr_c1_data   = '0;
    usr_c2        = '0;
    afu_rx        = '0;
    cap_c0_valid  = 1'b0;
    cap_c0_hdr    = '0;
    cap_rx        = '0;
    test_reset();
    test_reads();
    test_writes_c2();
    test_almfull();
    test_net_update();
    test_underflow();
    test_cap();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
